// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the ID-stage hazard controller: state encoding,
// register-zero constant and the per-stage enable/clear bundle.
package hazard_ctrl_pkg;

  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  localparam int STALL_CNT_W_DEF = 16;
  localparam logic [STALL_CNT_W_DEF-1:0] STALL_CNT_MAX = {STALL_CNT_W_DEF{1'b1}};

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_LU_STALL = 1'b1
  } st_e;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic ifid_clr;
    logic idex_en;
    logic idex_clr;
    logic exmem_en;
    logic exmem_clr;
  } ctl_t;

  // Clr is only ever raised on a stage whose En is also high.
  localparam ctl_t CTL_FREEZE = '{pc_en: 1'b0, ifid_en: 1'b0, ifid_clr: 1'b0, idex_en: 1'b0,
                                  idex_clr: 1'b0, exmem_en: 1'b0, exmem_clr: 1'b0};
  localparam ctl_t CTL_RUN    = '{pc_en: 1'b1, ifid_en: 1'b1, ifid_clr: 1'b0, idex_en: 1'b1,
                                  idex_clr: 1'b0, exmem_en: 1'b1, exmem_clr: 1'b0};
  localparam ctl_t CTL_STALL  = '{pc_en: 1'b0, ifid_en: 1'b0, ifid_clr: 1'b0, idex_en: 1'b1,
                                  idex_clr: 1'b1, exmem_en: 1'b1, exmem_clr: 1'b0};
  localparam ctl_t CTL_FLUSH  = '{pc_en: 1'b1, ifid_en: 1'b1, ifid_clr: 1'b1, idex_en: 1'b1,
                                  idex_clr: 1'b1, exmem_en: 1'b1, exmem_clr: 1'b1};

endpackage

// File: rtl/hazard_ctrl_lu_detect.sv
// Load-use comparator: flags an ID instruction that sources the register a load in EX writes.
// Purely combinational; shared with the forwarding unit.
module hazard_ctrl_lu_detect
  import hazard_ctrl_pkg::*;
(
  input  logic             ex_rd_mem_i,
  input  logic [REG_W-1:0] ex_dst_i,
  input  logic [REG_W-1:0] id_rs_i,
  input  logic [REG_W-1:0] id_rt_i,
  input  logic             id_uses_rt_i,
  output logic             lu_hit_o
);

  logic rs_match;
  logic rt_match;

  assign rs_match = (ex_dst_i == id_rs_i);
  assign rt_match = id_uses_rt_i & (ex_dst_i == id_rt_i);
  assign lu_hit_o = ex_rd_mem_i & (ex_dst_i != REG_ZERO) & (rs_match | rt_match);

endmodule

// File: rtl/hazard_ctrl.sv
// ID-stage hazard controller: per-stage En/Clr for load-use stalls, branch flushes and memory wait.
// Outputs are same-cycle combinational; a load-use stall lasts LU_BUBBLES cycles plus any busy cycles.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int LU_BUBBLES = 1,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       ID_rs,
  input  logic [4:0]       ID_rt,
  input  logic             ID_UsesRt,
  input  logic             EX_ReadMem,
  input  logic [4:0]       EX_Dst,
  input  logic             Branch_Taken,
  input  logic             Mem_Busy,
  input  logic             Cnt_Clr,
  output logic             PC_En,
  output logic             IFID_En,
  output logic             IFID_Clr,
  output logic             IDEX_En,
  output logic             IDEX_Clr,
  output logic             EXMEM_En,
  output logic             EXMEM_Clr,
  output logic [CNT_W-1:0] Stall_Cnt
);

  localparam logic [1:0]       BUB_INIT = 2'(LU_BUBBLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  st_e              st_q, st_d;
  logic [1:0]       bub_q, bub_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lu_hit;
  ctl_t             ctl;

  hazard_ctrl_lu_detect u_lu_detect (
    .ex_rd_mem_i  (EX_ReadMem),
    .ex_dst_i     (EX_Dst),
    .id_rs_i      (ID_rs),
    .id_rt_i      (ID_rt),
    .id_uses_rt_i (ID_UsesRt),
    .lu_hit_o     (lu_hit)
  );

  // Priority: reset > memory wait > branch flush > load-use stall > normal flow.
  always_comb begin
    ctl   = CTL_FREEZE;
    st_d  = st_q;
    bub_d = bub_q;
    if (!rst) begin
      ctl = CTL_FREEZE;
    end else if (Mem_Busy) begin
      ctl = CTL_FREEZE;
    end else if (Branch_Taken) begin
      ctl   = CTL_FLUSH;
      st_d  = ST_RUN;
      bub_d = 2'd0;
    end else if (st_q == ST_LU_STALL) begin
      ctl = CTL_STALL;
      if (bub_q == 2'd1) begin
        st_d  = ST_RUN;
        bub_d = 2'd0;
      end else begin
        bub_d = bub_q - 2'd1;
      end
    end else if (lu_hit) begin
      ctl = CTL_STALL;
      if (LU_BUBBLES > 1) begin
        st_d  = ST_LU_STALL;
        bub_d = BUB_INIT;
      end
    end else begin
      ctl = CTL_RUN;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (Cnt_Clr) begin
      cnt_d = '0;
    end else if (!ctl.pc_en && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q  <= ST_RUN;
      bub_q <= 2'd0;
      cnt_q <= '0;
    end else begin
      st_q  <= st_d;
      bub_q <= bub_d;
      cnt_q <= cnt_d;
    end
  end

  assign PC_En     = ctl.pc_en;
  assign IFID_En   = ctl.ifid_en;
  assign IFID_Clr  = ctl.ifid_clr;
  assign IDEX_En   = ctl.idex_en;
  assign IDEX_Clr  = ctl.idex_clr;
  assign EXMEM_En  = ctl.exmem_en;
  assign EXMEM_Clr = ctl.exmem_clr;
  assign Stall_Cnt = cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: three instances (1, 2 and 3 bubbles; the last with a 4-bit counter)
// share one stimulus stream and are checked against hand-computed En/Clr vectors and counts.
module tb_hazard_ctrl;

  // Output vector order: {PC_En, IFID_En, IFID_Clr, IDEX_En, IDEX_Clr, EXMEM_En, EXMEM_Clr}
  localparam logic [6:0] V_ZERO  = 7'b0000000;
  localparam logic [6:0] V_RUN   = 7'b1101010;
  localparam logic [6:0] V_STALL = 7'b0001110;
  localparam logic [6:0] V_FLUSH = 7'b1111111;

  logic       clk;
  logic       rst;
  logic [4:0] ID_rs, ID_rt, EX_Dst;
  logic       ID_UsesRt, EX_ReadMem, Branch_Taken, Mem_Busy, Cnt_Clr;

  logic [6:0]  ov1, ov2, ov3;
  logic [15:0] c1, c2;
  logic [3:0]  c3;

  int n_chk = 0;
  int n_err = 0;

  hazard_ctrl #(.LU_BUBBLES(1), .CNT_W(16)) u_dut1 (
    .clk(clk), .rst(rst), .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_UsesRt(ID_UsesRt),
    .EX_ReadMem(EX_ReadMem), .EX_Dst(EX_Dst), .Branch_Taken(Branch_Taken),
    .Mem_Busy(Mem_Busy), .Cnt_Clr(Cnt_Clr),
    .PC_En(ov1[6]), .IFID_En(ov1[5]), .IFID_Clr(ov1[4]), .IDEX_En(ov1[3]),
    .IDEX_Clr(ov1[2]), .EXMEM_En(ov1[1]), .EXMEM_Clr(ov1[0]), .Stall_Cnt(c1)
  );

  hazard_ctrl #(.LU_BUBBLES(2), .CNT_W(16)) u_dut2 (
    .clk(clk), .rst(rst), .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_UsesRt(ID_UsesRt),
    .EX_ReadMem(EX_ReadMem), .EX_Dst(EX_Dst), .Branch_Taken(Branch_Taken),
    .Mem_Busy(Mem_Busy), .Cnt_Clr(Cnt_Clr),
    .PC_En(ov2[6]), .IFID_En(ov2[5]), .IFID_Clr(ov2[4]), .IDEX_En(ov2[3]),
    .IDEX_Clr(ov2[2]), .EXMEM_En(ov2[1]), .EXMEM_Clr(ov2[0]), .Stall_Cnt(c2)
  );

  hazard_ctrl #(.LU_BUBBLES(3), .CNT_W(4)) u_dut3 (
    .clk(clk), .rst(rst), .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_UsesRt(ID_UsesRt),
    .EX_ReadMem(EX_ReadMem), .EX_Dst(EX_Dst), .Branch_Taken(Branch_Taken),
    .Mem_Busy(Mem_Busy), .Cnt_Clr(Cnt_Clr),
    .PC_En(ov3[6]), .IFID_En(ov3[5]), .IFID_Clr(ov3[4]), .IDEX_En(ov3[3]),
    .IDEX_Clr(ov3[2]), .EXMEM_En(ov3[1]), .EXMEM_Clr(ov3[0]), .Stall_Cnt(c3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    ID_rs = 5'd0; ID_rt = 5'd0; ID_UsesRt = 1'b0;
    EX_ReadMem = 1'b0; EX_Dst = 5'd0;
    Branch_Taken = 1'b0; Mem_Busy = 1'b0; Cnt_Clr = 1'b0;
  endtask

  task automatic hit();
    idle();
    EX_ReadMem = 1'b1; EX_Dst = 5'd8; ID_rs = 5'd8;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0;
    idle();
    #2;
    check("rst_o1", ov1, V_ZERO);
    check("rst_o3", ov3, V_ZERO);
    check("rst_cnt1", c1, 0);
    cyc();
    rst = 1'b1;
    @(negedge clk);
    check("run_o1", ov1, V_RUN);
    check("run_o2", ov2, V_RUN);
    check("run_o3", ov3, V_RUN);
    cyc();

    // Load-use on rs: 1, 2 and 3 bubble instances
    hit();
    @(negedge clk);
    check("lu_o1", ov1, V_STALL);
    check("lu_o2", ov2, V_STALL);
    check("lu_o3", ov3, V_STALL);
    cyc();
    idle();
    @(negedge clk);
    check("lu1_end", ov1, V_RUN);
    check("lu2_b2", ov2, V_STALL);
    check("lu3_b2", ov3, V_STALL);
    check("lu_cnt1", c1, 1);
    cyc();
    @(negedge clk);
    check("lu2_end", ov2, V_RUN);
    check("lu3_b3", ov3, V_STALL);
    check("lu_cnt2", c2, 2);
    cyc();
    @(negedge clk);
    check("lu3_end", ov3, V_RUN);
    check("lu_cnt3", c3, 3);
    cyc();

    // Non-hazards: register zero, rt match without rt use; then rt match with use
    EX_ReadMem = 1'b1; EX_Dst = 5'd0; ID_rs = 5'd0;
    @(negedge clk);
    check("r0_o1", ov1, V_RUN);
    check("r0_o3", ov3, V_RUN);
    cyc();
    EX_Dst = 5'd8; ID_rs = 5'd3; ID_rt = 5'd8; ID_UsesRt = 1'b0;
    @(negedge clk);
    check("rt_nouse", ov1, V_RUN);
    cyc();
    ID_UsesRt = 1'b1;
    @(negedge clk);
    check("rt_use", ov1, V_STALL);
    cyc();
    idle();
    repeat (3) cyc();
    Cnt_Clr = 1'b1;
    cyc();

    // Branch in first LU_STALL cycle aborts the stall
    hit();
    cyc();
    idle();
    Branch_Taken = 1'b1;
    @(negedge clk);
    check("br_o3", ov3, V_FLUSH);
    check("br_o2", ov2, V_FLUSH);
    check("br_o1", ov1, V_FLUSH);
    check("br_cnt3", c3, 1);
    cyc();
    idle();
    @(negedge clk);
    check("br_run3", ov3, V_RUN);
    check("br_run2", ov2, V_RUN);
    cyc();

    // Busy during LU_STALL with a pending branch: freeze, then flush
    Cnt_Clr = 1'b1;
    cyc();
    hit();
    cyc();
    idle();
    Mem_Busy = 1'b1;
    Branch_Taken = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("busy_o3", ov3, V_ZERO);
      cyc();
    end
    Mem_Busy = 1'b0;
    @(negedge clk);
    check("bf_o3", ov3, V_FLUSH);
    check("bf_cnt3", c3, 4);
    cyc();
    idle();
    @(negedge clk);
    check("bf_run3", ov3, V_RUN);
    cyc();

    // Busy without branch holds bub_cnt: remaining bubbles resume afterwards
    hit();
    cyc();
    idle();
    Mem_Busy = 1'b1;
    cyc();
    cyc();
    Mem_Busy = 1'b0;
    @(negedge clk);
    check("hold_s1_o3", ov3, V_STALL);
    check("hold_s1_o2", ov2, V_STALL);
    cyc();
    @(negedge clk);
    check("hold_s2_o3", ov3, V_STALL);
    check("hold_end_o2", ov2, V_RUN);
    cyc();
    @(negedge clk);
    check("hold_end_o3", ov3, V_RUN);
    cyc();

    // Saturation of the 4-bit counter; clear concurrent with a stall
    Cnt_Clr = 1'b1;
    cyc();
    idle();
    Mem_Busy = 1'b1;
    repeat (20) cyc();
    @(negedge clk);
    check("sat_cnt3", c3, 15);
    check("nosat_cnt1", c1, 20);
    Cnt_Clr = 1'b1;
    cyc();
    @(negedge clk);
    check("clr_cnt3", c3, 0);
    check("clr_cnt1", c1, 0);
    idle();
    cyc();

    // Asynchronous reset in the middle of a stall
    Cnt_Clr = 1'b1;
    cyc();
    hit();
    cyc();
    idle();
    Mem_Busy = 1'b1;
    repeat (4) cyc();
    @(negedge clk);
    check("pre_cnt3", c3, 5);
    idle();
    #1;
    check("pre_o3", ov3, V_STALL);
    rst = 1'b0;
    #1;
    check("arst_o3", ov3, V_ZERO);
    check("arst_o1", ov1, V_ZERO);
    check("arst_cnt3", c3, 0);
    cyc();
    rst = 1'b1;
    @(negedge clk);
    check("rel_o3", ov3, V_RUN);
    check("rel_o2", ov2, V_RUN);
    check("rel_cnt3", c3, 0);
    cyc();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
